// File: rtl/serial_subtractor_pkg.sv
// Shared types and width helpers for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Producer/consumer handshake bundle for the bit-serial subtractor.
interface serial_subtractor_if #(
  parameter int N = 8
);

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] diff;
  logic         bout;
  logic         ovf;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, ovf
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, ovf
  );

endinterface

// File: rtl/serial_subtractor_fs.sv
// One-bit full-subtractor cell: d = a - b - bin, with borrow-out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, LSB first, one bit per clock,
// with valid/ready handshakes on both sides.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int N = 8
) (
  input  logic               clk,
  input  logic               rst,
  serial_subtractor_if.slave bus
);

  localparam int             CW   = cnt_width(N);
  localparam logic [CW-1:0]  LAST = CW'(N - 1);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [N-1:0]  a_sr;
  logic [N-1:0]  b_sr;
  logic [N-1:0]  res;
  logic          borrow;
  logic          bout_q;
  logic          ovf_q;
  logic          d_bit;
  logic          bo_bit;
  logic          accept;
  logic          last;

  full_subtractor u_fs (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (borrow),
    .d    (d_bit),
    .bout (bo_bit)
  );

  assign accept = bus.in_valid && (state == IDLE);
  assign last   = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_nxt = RUN;
      RUN:     if (last)          state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // Control and result registers: cleared by reset so nothing partial survives.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      borrow <= 1'b0;
      res    <= '0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            borrow <= bus.bin;
            cnt    <= '0;
          end
        end
        RUN: begin
          res    <= {d_bit, res[N-1:1]};
          borrow <= bo_bit;
          cnt    <= last ? cnt : cnt + 1'b1;
          if (last) begin
            bout_q <= bo_bit;
            // borrow here is the borrow into the sign bit
            ovf_q  <= borrow ^ bo_bit;
          end
        end
        default: ;
      endcase
    end
  end

  // Operand shift registers: data only, qualified by the FSM.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_sr <= bus.a;
      b_sr <= bus.b;
    end else if (state == RUN) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.diff      = res;
  assign bus.bout      = bout_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed-vector bench for serial_subtractor with hand-computed results.
module tb_serial_subtractor;

  localparam int N = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  serial_subtractor_if #(.N(N)) bus ();

  serial_subtractor #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic bin,
                       input logic [N-1:0] ed, input logic eb, input logic eo,
                       input int hold, input bit stuff, input string tag);
    int cyc;
    bit busy_bad;
    bit hold_bad;
    @(negedge clk);
    check({tag, "_ready_idle"}, bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.bin      = bin;
    @(negedge clk);
    if (stuff) begin
      bus.a   = 8'hFF;
      bus.b   = 8'h00;
      bus.bin = 1'b1;
    end else begin
      bus.in_valid = 1'b0;
    end
    cyc      = 0;
    busy_bad = 0;
    while (!bus.out_valid && cyc < 4 * N) begin
      if (bus.in_ready) busy_bad = 1;
      @(negedge clk);
      cyc++;
    end
    bus.in_valid = 1'b0;
    check({tag, "_latency"}, cyc, N);
    check({tag, "_ready_low_run"}, busy_bad, 0);
    hold_bad = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!bus.out_valid || bus.in_ready || bus.diff !== ed || bus.bout !== eb || bus.ovf !== eo)
        hold_bad = 1;
    end
    if (hold > 0) check({tag, "_hold_stable"}, hold_bad, 0);
    check({tag, "_diff"}, bus.diff, ed);
    check({tag, "_bout"}, bus.bout, eb);
    check({tag, "_ovf"},  bus.ovf,  eo);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_ready_after"}, bus.in_ready, 1);
    check({tag, "_valid_after"}, bus.out_valid, 0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.bin       = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_ready", bus.in_ready, 1);
    check("rst_valid", bus.out_valid, 0);
    check("rst_diff",  bus.diff, 0);
    check("rst_bout",  bus.bout, 0);
    check("rst_ovf",   bus.ovf, 0);

    do_op(8'd5,  8'd3,  1'b0, 8'h02, 1'b0, 1'b0, 0, 0, "5m3");
    do_op(8'd3,  8'd5,  1'b0, 8'hFE, 1'b1, 1'b0, 0, 0, "3m5");
    do_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 0, 0, "80m01");
    do_op(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 0, 0, "7Fm FF");
    do_op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 0, 0, "0m0b1");
    do_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 0, 0, "FFmFFb1");
    do_op(8'd5,  8'd3,  1'b0, 8'h02, 1'b0, 1'b0, 5, 0, "backpressure");
    do_op(8'd3,  8'd5,  1'b0, 8'hFE, 1'b1, 1'b0, 0, 1, "stuffed_valid");

    // Abort a run after bits 0..3 have been processed.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a        = 8'hAA;
    bus.b        = 8'h11;
    bus.bin      = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_run_busy", bus.in_ready, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ready", bus.in_ready, 1);
    check("abort_valid", bus.out_valid, 0);
    check("abort_diff",  bus.diff, 0);
    check("abort_bout",  bus.bout, 0);
    check("abort_ovf",   bus.ovf, 0);
    do_op(8'd9, 8'd4, 1'b0, 8'h05, 1'b0, 1'b0, 0, 0, "after_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got hang, expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial two's-complement subtractor. Computes diff = a - b - bin over N clock cycles, one bit per cycle, LSB first.
- It is the inverse operation of the team's parallel adder datapath, traded for area: one full-subtractor cell plus shift registers.
- Sits between a producer and a consumer, each with a valid/ready handshake.
- Reports unsigned borrow-out and signed overflow.

Parameters:
- N, 8, operand and result width in bits; legal range 2..64.

Ports:
- clk  input  1  rising-edge clock (sole clock domain)
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  producer has operands a, b, bin
- in_ready  output  1  block can accept operands (high only in IDLE)
- a  input  N  minuend
- b  input  N  subtrahend
- bin  input  1  borrow-in
- out_valid  output  1  result fields are valid (high only in DONE)
- out_ready  input  1  consumer accepts result
- diff  output  N  a - b - bin, modulo 2^N
- bout  output  1  unsigned borrow-out (1 when a < b + bin as unsigned)
- ovf  output  1  signed overflow of a - b - bin

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk, rst).
- Reset values: state IDLE, in_ready=1, out_valid=0, diff=0, bout=0, ovf=0, bit counter=0, internal borrow=0.
- rst is sampled only at clk rising edge and overrides all other inputs.
- rst asserted mid-RUN or in DONE discards the operation; no partial result is ever presented.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready at an edge: load shift registers A<=a, B<=b; set borrow<=bin; counter<=0; go to RUN.
  - Input values while in_valid=0 are ignored.
- RUN:
  - in_ready=0, out_valid=0.
  - Each edge processes bit i = counter through the full-subtractor cell: d = A0^B0^borrow; bo = (~A0&B0) | (~(A0^B0)&borrow).
  - d shifts into the MSB of the result register, which shifts right. A and B shift right. borrow <= bo. counter++.
  - On the edge processing bit N-1: capture ovf = borrow-into-MSB ^ bo and bout = bo, then go to DONE.
- Latency: acceptance at edge E0; bits processed at edges E1..EN; out_valid is high in the cycle after EN, i.e. N edges after acceptance.
- DONE:
  - out_valid=1; diff, bout and ovf are held stable.
  - out_ready may stay low indefinitely; outputs do not change while waiting.
  - On out_valid & out_ready: go to IDLE.
  - There is no same-cycle reload. in_ready rises in the cycle after the output handshake. Maximum throughput is one operation per N+2 cycles.
- in_valid asserted during RUN or DONE is not accepted; the producer must hold it until in_ready.
- Outputs are registered only; there is no combinational path from any input to any output.
- Width rules:
  - Bit counter is clog2(N) bits and saturates at terminal count N-1; no wrap into garbage.
  - Result register is N bits; borrow is 1 bit.
  - Overflow uses the borrow-chain form, not operand-sign heuristics, so that bin=1 is correct.

Decomposition:
- Package serial_sub_pkg:
  - state enum typedef {IDLE, RUN, DONE}, 2 bits.
  - Localparam function for counter width, clog2(N) with a minimum of 1.
- Sub-module full_subtractor (inputs a, b, bin; outputs d, bout), purely combinational, instantiated once.

Test Plan:
- N=8, a=8'd5, b=8'd3, bin=0 -> after 8 edges diff=8'h02, bout=0, ovf=0; in_ready low for exactly the RUN+DONE period.
- a=8'd3, b=8'd5, bin=0 -> diff=8'hFE, bout=1, ovf=0.
- a=8'h80, b=8'h01, bin=0 -> diff=8'h7F, bout=0, ovf=1. Then a=8'h7F, b=8'hFF, bin=0 -> diff=8'h80, bout=1, ovf=1.
- a=8'h00, b=8'h00, bin=1 -> diff=8'hFF, bout=1, ovf=0 (exercises borrow-in on the chain).
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid and diff stable throughout. Hold in_valid=1 during RUN with new operands -> not accepted, and the first result is unaffected.
- Reset: assert rst at bit 4 of a RUN -> next cycle state IDLE, in_ready=1, out_valid=0, diff=0. A subsequent 8'd9 - 8'd4 yields 8'h05 with correct latency.
